// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the 640x480@60 Hz VGA raster timing generator.
package vga_timing_pkg;

    // Default horizontal segments, in pixels.
    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;

    // Default vertical segments, in lines.
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    // Default raster totals (800 pixels per line, 525 lines per frame).
    localparam int unsigned H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int unsigned V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // Inclusive counter range over which a sync output is driven low.
    typedef struct packed {
        logic [31:0] first;
        logic [31:0] last;
    } sync_window_t;

    // The sync pulse starts right after the front porch and lasts sync_len counts.
    function automatic sync_window_t sync_window(
        input int unsigned visible,
        input int unsigned front,
        input int unsigned sync_len
    );
        sync_window_t w;
        w.first = visible + front;
        w.last  = visible + front + sync_len - 1;
        return w;
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-enable divider: strobes once every CLK_DIV clock cycles.
// Pixel_Tick is a combinational decode of the divider register, high while
// div_cnt sits at CLK_DIV-1, i.e. on the cycle whose closing edge ends a pixel.
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic Clk,
    input  logic Reset,
    output logic Pixel_Tick
);

    localparam int unsigned      DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q;
    logic [DIV_W-1:0] div_cnt_d;

    // Next divider value: count up and wrap after CLK_DIV-1.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DIV_LAST) begin
            div_cnt_d = '0;
        end
    end

    // Divider register, cleared by reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

    assign Pixel_Tick = (div_cnt_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: horizontal/vertical counters advanced by the pixel divider,
// followed by one register stage so coordinates, syncs, Video_On, Frame_Start and
// Pixel_Tick all change together, one clock behind the counter state.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        Pixel_Tick,
    output logic [15:0] Xpos,
    output logic [15:0] Ypos,
    output logic        Hsync,
    output logic        Vsync,
    output logic        Video_On,
    output logic        Frame_Start
);

    localparam int unsigned H_TOT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_W   = $clog2(H_TOT);
    localparam int unsigned V_W   = $clog2(V_TOT);

    localparam sync_window_t H_WIN = sync_window(H_VISIBLE, H_FRONT, H_SYNC);
    localparam sync_window_t V_WIN = sync_window(V_VISIBLE, V_FRONT, V_SYNC);

    localparam logic [H_W-1:0] H_MAX    = H_W'(H_TOT - 1);
    localparam logic [V_W-1:0] V_MAX    = V_W'(V_TOT - 1);
    localparam logic [H_W-1:0] H_VIS    = H_W'(H_VISIBLE);
    localparam logic [V_W-1:0] V_VIS    = V_W'(V_VISIBLE);
    localparam logic [H_W-1:0] HS_FIRST = H_W'(H_WIN.first);
    localparam logic [H_W-1:0] HS_LAST  = H_W'(H_WIN.last);
    localparam logic [V_W-1:0] VS_FIRST = V_W'(V_WIN.first);
    localparam logic [V_W-1:0] VS_LAST  = V_W'(V_WIN.last);

    // Divider strobe: the counters step on the edge that closes this cycle.
    logic pix_strobe;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .Pixel_Tick (pix_strobe)
    );

    // Counter state.
    logic [H_W-1:0] h_cnt_q;
    logic [H_W-1:0] h_cnt_d;
    logic [V_W-1:0] v_cnt_q;
    logic [V_W-1:0] v_cnt_d;
    // High for the first cycle a new counter state is held; keeps Frame_Start to a
    // single clock even though (0,0) is held for CLK_DIV cycles.
    logic           fresh_q;

    // Output register stage.
    logic           pixel_tick_q;
    logic [15:0]    xpos_q;
    logic [15:0]    xpos_d;
    logic [15:0]    ypos_q;
    logic [15:0]    ypos_d;
    logic           hsync_q;
    logic           hsync_d;
    logic           vsync_q;
    logic           vsync_d;
    logic           video_on_q;
    logic           video_on_d;
    logic           frame_start_q;
    logic           frame_start_d;

    logic           h_wrap;
    logic           v_wrap;

    // Next counter values: h steps on each strobe, v steps when h wraps.
    // Anything past the last count (unreachable after reset) also wraps to 0.
    always_comb begin
        h_wrap  = (h_cnt_q == H_MAX) || (h_cnt_q > H_MAX);
        v_wrap  = (v_cnt_q == V_MAX) || (v_cnt_q > V_MAX);
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_strobe) begin
            if (h_wrap) begin
                h_cnt_d = '0;
                if (v_wrap) begin
                    v_cnt_d = '0;
                end else begin
                    v_cnt_d = v_cnt_q + 1'b1;
                end
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers; reset restarts the raster at (0,0) immediately.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            fresh_q <= 1'b1;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            fresh_q <= pix_strobe;
        end
    end

    // Decode the current counter state into the values the output stage captures.
    always_comb begin
        xpos_d        = 16'(h_cnt_q);
        ypos_d        = 16'(v_cnt_q);
        hsync_d       = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
        vsync_d       = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
        video_on_d    = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        frame_start_d = fresh_q && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    // Output registers; on reset the syncs go inactive (high) at once.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pixel_tick_q  <= 1'b0;
            xpos_q        <= '0;
            ypos_q        <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            pixel_tick_q  <= pix_strobe;
            xpos_q        <= xpos_d;
            ypos_q        <= ypos_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign Pixel_Tick  = pixel_tick_q;
    assign Xpos        = xpos_q;
    assign Ypos        = ypos_q;
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign Video_On    = video_on_q;
    assign Frame_Start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (CLK_DIV=2 and CLK_DIV=1) with the
// default horizontal timing and a shortened 15-line frame, checked every clock
// against an arithmetic model of the raster position.
module tb_vga_timing_gen;

    // Bench geometry: default line, short frame (8 visible + 2 + 2 + 3 lines).
    localparam int H_T      = 800;
    localparam int V_T      = 15;
    localparam int HS_FIRST = 656;
    localparam int HS_LAST  = 751;
    localparam int VS_FIRST = 10;
    localparam int VS_LAST  = 11;
    localparam int X_VIS    = 640;
    localparam int Y_VIS    = 8;
    // Clock after release at which instance A shows (700,10) in its second frame.
    localparam int MID_N    = 2 * (H_T * V_T + VS_FIRST * H_T + 700) + 1;

    localparam logic [36:0] RESET_EXP = {16'd0, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUTs ----------------
    logic        pt_a, hs_a, vs_a, vo_a, fs_a;
    logic [15:0] x_a, y_a;
    logic        pt_b, hs_b, vs_b, vo_b, fs_b;
    logic [15:0] x_b, y_b;

    vga_timing_gen #(
        .CLK_DIV   (2),
        .H_VISIBLE (640), .H_FRONT (16), .H_SYNC (96), .H_BACK (48),
        .V_VISIBLE (8),   .V_FRONT (2),  .V_SYNC (2),  .V_BACK (3)
    ) dut_a (
        .Clk         (clk),
        .Reset       (rst),
        .Pixel_Tick  (pt_a),
        .Xpos        (x_a),
        .Ypos        (y_a),
        .Hsync       (hs_a),
        .Vsync       (vs_a),
        .Video_On    (vo_a),
        .Frame_Start (fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV   (1),
        .H_VISIBLE (640), .H_FRONT (16), .H_SYNC (96), .H_BACK (48),
        .V_VISIBLE (8),   .V_FRONT (2),  .V_SYNC (2),  .V_BACK (3)
    ) dut_b (
        .Clk         (clk),
        .Reset       (rst),
        .Pixel_Tick  (pt_b),
        .Xpos        (x_b),
        .Ypos        (y_b),
        .Hsync       (hs_b),
        .Vsync       (vs_b),
        .Video_On    (vo_b),
        .Frame_Start (fs_b)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Expected outputs n clocks after reset release (n >= 1), divider d.
    // The raster position shown is floor((n-1)/d) pixels into the frame.
    function automatic logic [36:0] model_out(input int n, input int d);
        int   idx, x, y;
        logic hs, vs, vo, fs, pt;
        idx = ((n - 1) / d) % (H_T * V_T);
        x   = idx % H_T;
        y   = idx / H_T;
        hs  = !(x >= HS_FIRST && x <= HS_LAST);
        vs  = !(y >= VS_FIRST && y <= VS_LAST);
        vo  = (x < X_VIS) && (y < Y_VIS);
        fs  = (((n - 1) % (d * H_T * V_T)) == 0);
        pt  = ((n % d) == 0);
        return {x[15:0], y[15:0], hs, vs, vo, fs, pt};
    endfunction

    // ---------------- scoreboard ----------------
    logic [36:0] exp_a_q[$];
    logic [36:0] exp_b_q[$];
    int          n_clk       = 0;
    logic        rst_at_edge = 1'b0;
    int          cyc         = 0;

    // Each edge: record whether reset was sampled and queue what each DUT must show.
    initial begin
        forever begin
            @(posedge clk);
            rst_at_edge = rst;
            if (rst) begin
                n_clk = 0;
                exp_a_q.push_back(RESET_EXP);
                exp_b_q.push_back(RESET_EXP);
            end else begin
                n_clk++;
                exp_a_q.push_back(model_out(n_clk, 2));
                exp_b_q.push_back(model_out(n_clk, 1));
            end
        end
    end

    // Per-instance run-length and transition monitors.
    int hs_run[2];
    int vs_run[2];
    int last_fs[2];
    int prev_x[2];
    int prev_y[2];
    logic prev_vo[2];

    task automatic monitor(input int id, input string nm, input int d, input logic [36:0] got);
        int   x, y;
        logic hs, vs, vo, fs;
        x  = int'(got[36:21]);
        y  = int'(got[20:5]);
        hs = got[4];
        vs = got[3];
        vo = got[2];
        fs = got[1];
        if (rst_at_edge) begin
            hs_run[id]  = 0;
            vs_run[id]  = 0;
            last_fs[id] = -1;
            prev_vo[id] = 1'b0;
        end else begin
            if (!hs) begin
                hs_run[id]++;
            end else begin
                if (hs_run[id] > 0) check_val({nm, "_hsync_len"}, 64'(hs_run[id]), 64'(96 * d));
                hs_run[id] = 0;
            end
            if (!vs) begin
                vs_run[id]++;
            end else begin
                if (vs_run[id] > 0) check_val({nm, "_vsync_len"}, 64'(vs_run[id]), 64'(2 * H_T * d));
                vs_run[id] = 0;
            end
            if (fs) begin
                if (last_fs[id] >= 0) check_val({nm, "_frame_period"}, 64'(cyc - last_fs[id]), 64'(d * H_T * V_T));
                last_fs[id] = cyc;
            end
            if (prev_vo[id] && !vo) check_val({nm, "_vo_fall_x"}, 64'(x), 64'(X_VIS));
            if (prev_x[id] == H_T - 1 && x == 0) check_val({nm, "_y_step"}, 64'(y), 64'((prev_y[id] + 1) % V_T));
            prev_vo[id] = vo;
        end
        prev_x[id] = x;
        prev_y[id] = y;
    endtask

    // Away from the active edge: pop one expectation per DUT and compare.
    initial begin
        logic [36:0] got_a, got_b, e;
        for (int i = 0; i < 2; i++) begin
            hs_run[i] = 0; vs_run[i] = 0; last_fs[i] = -1;
            prev_x[i] = 0; prev_y[i] = 0; prev_vo[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            cyc++;
            got_a = {x_a, y_a, hs_a, vs_a, vo_a, fs_a, pt_a};
            got_b = {x_b, y_b, hs_b, vs_b, vo_b, fs_b, pt_b};
            check_val("a_q_depth", 64'(exp_a_q.size()), 64'd1);
            if (exp_a_q.size() > 0) begin
                e = exp_a_q.pop_front();
                check_val("a_xy", 64'(got_a[36:5]), 64'(e[36:5]));
                check_val("a_flags", 64'(got_a[4:0]), 64'(e[4:0]));
            end
            check_val("b_q_depth", 64'(exp_b_q.size()), 64'd1);
            if (exp_b_q.size() > 0) begin
                e = exp_b_q.pop_front();
                check_val("b_xy", 64'(got_b[36:5]), 64'(e[36:5]));
                check_val("b_flags", 64'(got_b[4:0]), 64'(e[4:0]));
            end
            monitor(0, "a", 2, got_a);
            monitor(1, "b", 1, got_b);
        end
    end

    // ---------------- driver ----------------
    initial begin
        rst = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // First clock after release.
        @(negedge clk);
        check_val("rel_x",    64'(x_a),  64'd0);
        check_val("rel_y",    64'(y_a),  64'd0);
        check_val("rel_vo",   64'(vo_a), 64'd1);
        check_val("rel_hs",   64'(hs_a), 64'd1);
        check_val("rel_vs",   64'(vs_a), 64'd1);
        check_val("rel_fs",   64'(fs_a), 64'd1);
        check_val("rel_pt1",  64'(pt_a), 64'd0);
        check_val("rel_b_pt", 64'(pt_b), 64'd1);

        // Second clock: first tick, coordinate still held, no second frame pulse.
        @(negedge clk);
        check_val("rel_pt2",  64'(pt_a), 64'd1);
        check_val("rel_fs2",  64'(fs_a), 64'd0);
        check_val("rel_x2",   64'(x_a),  64'd0);
        check_val("rel_b_x2", 64'(x_b),  64'd1);

        // Run on into the second frame, to (700,10) where both syncs are low.
        repeat (MID_N - 2) @(negedge clk);
        check_val("mid_x",  64'(x_a),  64'd700);
        check_val("mid_y",  64'(y_a),  64'(VS_FIRST));
        check_val("mid_hs", 64'(hs_a), 64'd0);
        check_val("mid_vs", 64'(vs_a), 64'd0);

        // One-clock reset mid-frame.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("mrst_x",  64'(x_a),  64'd0);
        check_val("mrst_y",  64'(y_a),  64'd0);
        check_val("mrst_vo", 64'(vo_a), 64'd0);
        check_val("mrst_hs", 64'(hs_a), 64'd1);
        check_val("mrst_vs", 64'(vs_a), 64'd1);
        check_val("mrst_fs", 64'(fs_a), 64'd0);

        @(negedge clk);
        check_val("mrel_fs", 64'(fs_a), 64'd1);
        check_val("mrel_vo", 64'(vo_a), 64'd1);

        repeat (2000) @(negedge clk);
        #2;
        check_val("a_q_drained", 64'(exp_a_q.size()), 64'd0);
        check_val("b_q_drained", 64'(exp_b_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
